// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding, rate codes
// and the rate-to-divider reload mapping.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_HOLD  = 2'b11
    } sw_state_t;

    localparam logic [1:0] RATE_FAST = 2'b00;
    localparam logic [1:0] RATE_X1   = 2'b01;
    localparam logic [1:0] RATE_X2   = 2'b10;
    localparam logic [1:0] RATE_X4   = 2'b11;

    // Divider reload value (period - 1) for a given rate selection.
    function automatic logic [31:0] reload_value(input logic [1:0] rate_sel,
                                                 input logic [31:0] base_period);
        logic [31:0] period_v;
        case (rate_sel)
            RATE_FAST: period_v = 32'd1;
            RATE_X1:   period_v = base_period;
            RATE_X2:   period_v = base_period << 1;
            RATE_X4:   period_v = base_period << 2;
            default:   period_v = base_period;
        endcase
        return period_v - 32'd1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_button_edge.sv
// Button conditioner: 2-flop synchronizer and falling-edge detector that
// yields one single-cycle event per press of an active-low button.
module button_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic button_n,
    output logic press
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer and history flops idle high so reset exit never looks like a press.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= button_n;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign press = prev_r & ~sync2_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop, lap freeze and clear buttons driving a
// 4-bit count advanced by a programmable tick divider.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 50000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go_n,
    input  logic       lap_n,
    input  logic       clear_n,
    input  logic [1:0] rate_sel,
    output logic [3:0] count,
    output logic [3:0] display,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    localparam logic [31:0] BASE_PERIOD_C = 32'(BASE_PERIOD);

    sw_state_t   state_r;
    sw_state_t   next_state_s;
    logic        go_s;
    logic        lap_s;
    logic        clear_s;
    logic [31:0] div_r;
    logic [31:0] reload_s;
    logic [3:0]  count_r;
    logic [3:0]  count_next_s;
    logic [3:0]  display_r;
    logic        tick_r;
    logic        wrap_r;
    logic        running_r;
    logic        active_s;
    logic        inc_s;

    button_edge u_go    (.clock(clock), .reset_n(reset_n), .button_n(go_n),    .press(go_s));
    button_edge u_lap   (.clock(clock), .reset_n(reset_n), .button_n(lap_n),   .press(lap_s));
    button_edge u_clear (.clock(clock), .reset_n(reset_n), .button_n(clear_n), .press(clear_s));

    assign reload_s = reload_value(rate_sel, BASE_PERIOD_C);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; clear outranks go, go outranks lap.
    always_comb begin
        next_state_s = state_r;
        if (clear_s) begin
            next_state_s = ST_IDLE;
        end else if (go_s) begin
            case (state_r)
                ST_IDLE:  next_state_s = ST_RUN;
                ST_RUN:   next_state_s = ST_PAUSE;
                ST_PAUSE: next_state_s = ST_RUN;
                ST_HOLD:  next_state_s = ST_PAUSE;
                default:  next_state_s = ST_IDLE;
            endcase
        end else if (lap_s) begin
            case (state_r)
                ST_RUN:  next_state_s = ST_HOLD;
                ST_HOLD: next_state_s = ST_RUN;
                default: next_state_s = state_r;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Output decode: divider/count advance only while RUN or HOLD.
    always_comb begin
        active_s = 1'b0;
        case (state_r)
            ST_RUN, ST_HOLD: active_s = 1'b1;
            default:         active_s = 1'b0;
        endcase
        inc_s        = active_s && (div_r == 32'd0);
        count_next_s = inc_s ? (count_r + 4'd1) : count_r;
    end

    // Divider, count, lap display and registered status/pulse outputs.
    always_ff @(posedge clock) begin
        if (!reset_n || clear_s) begin
            div_r     <= reload_s;
            count_r   <= 4'd0;
            display_r <= 4'd0;
            tick_r    <= 1'b0;
            wrap_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            // IDLE tracks rate_sel; otherwise rate_sel is only picked up on reload.
            if (state_r == ST_IDLE) begin
                div_r <= reload_s;
            end else if (active_s) begin
                div_r <= (div_r == 32'd0) ? reload_s : (div_r - 32'd1);
            end else begin
                div_r <= div_r;
            end
            count_r   <= count_next_s;
            tick_r    <= inc_s;
            wrap_r    <= inc_s && (count_r == 4'd15);
            running_r <= (next_state_s == ST_RUN) || (next_state_s == ST_HOLD);
            if (next_state_s == ST_HOLD) begin
                display_r <= (state_r == ST_HOLD) ? display_r : count_r;
            end else begin
                display_r <= count_next_s;
            end
        end
    end

    assign count   = count_r;
    assign display = display_r;
    assign running = running_r;
    assign tick    = tick_r;
    assign wrap    = wrap_r;

endmodule
